// File: rtl/clock_set_ctrl.sv
// Button-driven mode select and time-set sequencer for the multi-mode clock.
// Optional auto-repeat on held up/down buttons is enabled by defining CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl #(
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned BLINK_MS        = 250,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 100
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       btn_mode_i,
  input  logic       btn_next_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  output logic [1:0] mode_o,
  output logic [5:0] set_hrs_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       set_time_o,
  output logic [1:0] edit_o,
  output logic       blink_o
);

  typedef enum logic [2:0] {StIdle, StSetHrs, StSetMin, StSetSec, StLoad} state_e;

  localparam int unsigned NumBtn = 4;

  // Button index: 0 mode, 1 next, 2 up, 3 down.
  logic [NumBtn-1:0] btn_raw;
  logic [NumBtn-1:0] sync1_q, sync2_q, deb_q, deb_d, deb_prev_q, ev;
  logic [15:0]       db_cnt_q [NumBtn];
  logic [15:0]       db_cnt_d [NumBtn];

  state_e     state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [5:0] w_hrs_q, w_hrs_d, w_min_q, w_min_d, w_sec_q, w_sec_d;
  logic [5:0] set_hrs_q, set_hrs_d, set_min_q, set_min_d, set_sec_q, set_sec_d;
  logic       set_time_q, set_time_d;
  logic       blink_q, blink_d;
  logic [15:0] blink_cnt_q, blink_cnt_d;
  logic       in_set_q, in_set_d;
  logic       rep_up, rep_dn, inc, dec;

  assign btn_raw = {btn_down_i, btn_up_i, btn_next_i, btn_mode_i};
  assign ev      = deb_q & ~deb_prev_q;

  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < NumBtn; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick_i) begin
        if (db_cnt_q[i] == 16'(DEBOUNCE_MS - 1)) begin
          deb_d[i]    = sync2_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 16'd1;
        end
      end
    end
  end

  assign in_set_q = (state_q == StSetHrs) || (state_q == StSetMin) || (state_q == StSetSec);
  assign in_set_d = (state_d == StSetHrs) || (state_d == StSetMin) || (state_d == StSetSec);

`ifdef CLOCK_SET_AUTOREPEAT_EN
  logic [15:0] rep_cnt_q, rep_cnt_d;
  logic        rep_arm_q, rep_arm_d, rep_fire;

  always_comb begin
    rep_cnt_d = rep_cnt_q;
    rep_arm_d = rep_arm_q;
    rep_fire  = 1'b0;
    // Only a single held up or down button auto-repeats; any field change restarts the delay.
    if (!in_set_q || !(deb_q[2] ^ deb_q[3]) || (state_d != state_q)) begin
      rep_cnt_d = '0;
      rep_arm_d = 1'b0;
    end else if (tick_i) begin
      if (!rep_arm_q && rep_cnt_q == 16'(REPEAT_DELAY_MS - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
        rep_arm_d = 1'b1;
      end else if (rep_arm_q && rep_cnt_q == 16'(REPEAT_RATE_MS - 1)) begin
        rep_fire  = 1'b1;
        rep_cnt_d = '0;
      end else begin
        rep_cnt_d = rep_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rep_cnt_q <= '0;
      rep_arm_q <= 1'b0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
      rep_arm_q <= rep_arm_d;
    end
  end

  assign rep_up = rep_fire & deb_q[2];
  assign rep_dn = rep_fire & deb_q[3];
`else
  logic unused_repeat_params;
  assign unused_repeat_params = ^{REPEAT_DELAY_MS, REPEAT_RATE_MS};
  assign rep_up = 1'b0;
  assign rep_dn = 1'b0;
`endif

  assign inc = ev[2] | rep_up;
  assign dec = ev[3] | rep_dn;

  function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max_v,
                                            input logic up, input logic dn);
    if (up && !dn) return (v == max_v) ? 6'd0 : v + 6'd1;
    if (dn && !up) return (v == 6'd0) ? max_v : v - 6'd1;
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    w_hrs_d    = w_hrs_q;
    w_min_d    = w_min_q;
    w_sec_d    = w_sec_q;
    set_hrs_d  = set_hrs_q;
    set_min_d  = set_min_q;
    set_sec_d  = set_sec_q;
    set_time_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (ev[0]) begin
          mode_d = mode_q + 2'd1;
        end else if (ev[1]) begin
          w_hrs_d = set_hrs_q;
          w_min_d = set_min_q;
          w_sec_d = set_sec_q;
          state_d = StSetHrs;
        end
      end
      StSetHrs, StSetMin, StSetSec: begin
        if (ev[0]) begin
          state_d = StIdle;
        end else if (ev[1]) begin
          case (state_q)
            StSetHrs: state_d = StSetMin;
            StSetMin: state_d = StSetSec;
            default: begin
              // Commit on entry so the values and strobe are visible during the LOAD cycle.
              state_d    = StLoad;
              set_hrs_d  = w_hrs_q;
              set_min_d  = w_min_q;
              set_sec_d  = w_sec_q;
              set_time_d = 1'b1;
            end
          endcase
        end else begin
          case (state_q)
            StSetHrs: w_hrs_d = step_field(w_hrs_q, 6'd23, inc, dec);
            StSetMin: w_min_d = step_field(w_min_q, 6'd59, inc, dec);
            default:  w_sec_d = step_field(w_sec_q, 6'd59, inc, dec);
          endcase
        end
      end
      StLoad:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (!in_set_d) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (tick_i) begin
      if (blink_cnt_q == 16'(BLINK_MS - 1)) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      db_cnt_q    <= '{default: '0};
      state_q     <= StIdle;
      mode_q      <= 2'd0;
      w_hrs_q     <= '0;
      w_min_q     <= '0;
      w_sec_q     <= '0;
      set_hrs_q   <= 6'd12;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      set_time_q  <= 1'b0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      mode_q      <= mode_d;
      w_hrs_q     <= w_hrs_d;
      w_min_q     <= w_min_d;
      w_sec_q     <= w_sec_d;
      set_hrs_q   <= set_hrs_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      set_time_q  <= set_time_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
    end
  end

  always_comb begin
    case (state_q)
      StSetHrs: edit_o = 2'd1;
      StSetMin: edit_o = 2'd2;
      StSetSec: edit_o = 2'd3;
      default:  edit_o = 2'd0;
    endcase
  end

  assign mode_o     = mode_q;
  assign set_hrs_o  = set_hrs_q;
  assign set_min_o  = set_min_q;
  assign set_sec_o  = set_sec_q;
  assign set_time_o = set_time_q;
  assign blink_o    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed self-checking bench for clock_set_ctrl (DEBOUNCE_MS = 4, tick every cycle).
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b1;
  logic [3:0] btn = 4'b0;  // {down, up, next, mode}
  logic [1:0] mode_o, edit_o;
  logic [5:0] set_hrs_o, set_min_o, set_sec_o;
  logic       set_time_o, blink_o;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  localparam logic [3:0] BMode = 4'b0001;
  localparam logic [3:0] BNext = 4'b0010;
  localparam logic [3:0] BUp   = 4'b0100;
  localparam logic [3:0] BDown = 4'b1000;

  clock_set_ctrl #(
    .DEBOUNCE_MS    (4),
    .BLINK_MS       (8),
    .REPEAT_DELAY_MS(10),
    .REPEAT_RATE_MS (5)
  ) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .tick_i     (tick),
    .btn_mode_i (btn[0]),
    .btn_next_i (btn[1]),
    .btn_up_i   (btn[2]),
    .btn_down_i (btn[3]),
    .mode_o     (mode_o),
    .set_hrs_o  (set_hrs_o),
    .set_min_o  (set_min_o),
    .set_sec_o  (set_sec_o),
    .set_time_o (set_time_o),
    .edit_o     (edit_o),
    .blink_o    (blink_o)
  );

  always #5 clk = ~clk;

  // Counts high cycles, so a stretched strobe shows up as an extra count.
  always @(posedge clk) if (set_time_o === 1'b1) strobe_cnt <= strobe_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m);
    @(negedge clk);
    btn = m;
    cycles(8);
    btn = 4'b0;
    cycles(10);
  endtask

  task automatic press_n(input logic [3:0] m, input int n);
    for (int i = 0; i < n; i++) press(m);
  endtask

  initial begin
    bit found;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    check("rst_mode", mode_o, 0);
    check("rst_hrs", set_hrs_o, 12);
    check("rst_min", set_min_o, 0);
    check("rst_sec", set_sec_o, 0);
    check("rst_strobe", set_time_o, 0);
    check("rst_edit", edit_o, 0);
    check("rst_blink", blink_o, 0);

    // Mode stepping and wrap
    press(BMode); check("mode_1", mode_o, 1);
    press(BMode); check("mode_2", mode_o, 2);
    press(BMode); check("mode_3", mode_o, 3);
    press(BMode); check("mode_0", mode_o, 0);
    @(negedge clk);
    btn = BMode;
    cycles(2);
    btn = 4'b0;
    cycles(15);
    check("glitch_mode", mode_o, 0);
    press(BMode); check("mode_again", mode_o, 1);

    // Enter SET_HRS, watch blink phase from entry
    @(negedge clk);
    btn = BNext;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (edit_o != 2'd0) begin
        found = 1'b1;
        break;
      end
    end
    check("enter_found", found, 1);
    check("blink_start", blink_o, 1);
    cycles(4); check("blink_hold", blink_o, 1);
    cycles(5); check("blink_toggle", blink_o, 0);
    cycles(8); check("blink_back", blink_o, 1);
    btn = 4'b0;
    cycles(10);
    check("edit_hrs_a", edit_o, 1);
    press(BUp);
    press(BMode);
    check("abort_edit", edit_o, 0);
    check("abort_hrs", set_hrs_o, 12);
    check("abort_mode", mode_o, 1);
    check("abort_strobe", strobe_cnt, 0);
    check("abort_blink", blink_o, 0);

    // Full edit: 15:59:02
    press(BNext);      check("edit_hrs", edit_o, 1);
    press_n(BUp, 3);
    press(BNext);      check("edit_min", edit_o, 2);
    press(BDown);
    press(BNext);      check("edit_sec", edit_o, 3);
    press_n(BUp, 2);
    check("pre_load_hrs", set_hrs_o, 12);
    press(BNext);
    check("load_edit", edit_o, 0);
    check("load_hrs", set_hrs_o, 15);
    check("load_min", set_min_o, 59);
    check("load_sec", set_sec_o, 2);
    check("load_strobe", strobe_cnt, 1);

    // Simultaneous events in SET_SEC
    press_n(BNext, 3); check("sim_edit", edit_o, 3);
    press(BUp | BDown);
    press(BNext | BUp);
    check("sim_edit_after", edit_o, 0);
    check("sim_sec", set_sec_o, 2);
    check("sim_min", set_min_o, 59);
    check("sim_strobe", strobe_cnt, 2);

    // Hour wrap 23 -> 0 and 0 -> 23, minute wrap 59 -> 0
    press(BNext);
    press_n(BUp, 9);
    press_n(BNext, 3);
    check("wrap_hrs_up", set_hrs_o, 0);
    press(BNext);
    press(BDown);
    press_n(BNext, 3);
    check("wrap_hrs_dn", set_hrs_o, 23);
    press_n(BNext, 2);
    press(BUp);
    press_n(BNext, 2);
    check("wrap_min_up", set_min_o, 0);
    check("wrap_strobe", strobe_cnt, 5);

    // Asynchronous reset mid SET_MIN
    press_n(BNext, 2);
    check("pre_rst_edit", edit_o, 2);
    press(BUp);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mode", mode_o, 0);
    check("mid_rst_hrs", set_hrs_o, 12);
    check("mid_rst_min", set_min_o, 0);
    check("mid_rst_sec", set_sec_o, 0);
    check("mid_rst_strobe", set_time_o, 0);
    check("mid_rst_edit", edit_o, 0);
    check("mid_rst_blink", blink_o, 0);
    cycles(3);
    rst = 1'b0;
    cycles(3);

    // Held up from min = 58
    press_n(BNext, 2);
    press_n(BDown, 2);
    @(negedge clk);
    btn = BUp;
    cycles(32);
    btn = 4'b0;
    cycles(12);
    press_n(BNext, 2);
`ifdef CLOCK_SET_AUTOREPEAT_EN
    check("hold_min", set_min_o, 4);
`else
    check("hold_min", set_min_o, 59);
`endif
    check("hold_hrs", set_hrs_o, 12);
    check("hold_strobe", strobe_cnt, 6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven controller for the multi-mode clock. It selects the display mode (12 h, 24 h, timer, stopwatch) and sequences the user through editing hours, minutes and seconds. It then presents the new time to the clock/stopwatch datapath with a one-cycle load strobe. It sits between the board push-buttons and the set/mode inputs of the clock top level, and runs on the system clock with a 1 kHz enable from the clock divider.

## Interface
- `DEBOUNCE_MS`, default 20: ticks a raw button must be stable before its level is accepted.
- `BLINK_MS`, default 250: half-period, in ticks, of the edit-field blink.
- `REPEAT_DELAY_MS`, default 500: hold time, in ticks, before auto-repeat starts (only with the macro).
- `REPEAT_RATE_MS`, default 100: ticks between auto-repeat steps (only with the macro).
- `clk_i` input, 1 bit: system clock.
- `reset_i` input, 1 bit: asynchronous, active-high reset.
- `tick_i` input, 1 bit: 1 kHz single-cycle enable; all timing counters advance only on `tick_i`.
- `btn_mode_i`, `btn_next_i`, `btn_up_i`, `btn_down_i` inputs, 1 bit each: raw, asynchronous, active-high buttons.
- `mode_o` output, 2 bits: 00 = 12 h, 01 = 24 h, 10 = timer, 11 = stopwatch.
- `set_hrs_o` output, 6 bits: committed hours, 0–23.
- `set_min_o` output, 6 bits: committed minutes, 0–59.
- `set_sec_o` output, 6 bits: committed seconds, 0–59.
- `set_time_o` output, 1 bit: one-`clk_i`-cycle load strobe.
- `edit_o` output, 2 bits: field being edited. 0 = none, 1 = hrs, 2 = min, 3 = sec.
- `blink_o` output, 1 bit: blink phase for the edited field; 0 when not editing.

## Operation
- **Input conditioning.** Each button passes through a 2-flop synchronizer, then a per-button debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_MS` consecutive ticks.
  - An *event* is the single-cycle rising edge of the debounced level.
- **Registers.** The controller keeps working registers `w_hrs`, `w_min`, `w_sec`, separate from the committed outputs. The outputs change only in LOAD.
- **FSM states:** IDLE, SET_HRS, SET_MIN, SET_SEC, LOAD.
- **IDLE** (`edit_o` = 0):
  - mode event: `mode_o` increments, wrapping 11 → 00.
  - next event: copy the committed values into the working registers, then go to SET_HRS.
  - up/down events are ignored.
- **SET_HRS / SET_MIN / SET_SEC** (`edit_o` = 1 / 2 / 3):
  - up: increment the field. Hours wrap 23 → 0; minutes and seconds wrap 59 → 0.
  - down: decrement the field. Hours wrap 0 → 23; minutes and seconds wrap 0 → 59.
  - next: advance HRS → MIN → SEC → LOAD.
  - mode: abort to IDLE. The working values are discarded, no strobe is issued, and `mode_o` is unchanged.
- **LOAD:** copy the working registers to `set_*_o`, assert `set_time_o`, and return to IDLE. This state lasts one cycle.
- **Simultaneous events in the same cycle:**
  - mode beats next, and next beats up/down.
  - up together with down: both are ignored.
- **Blink.** The blink counter restarts at 0 on every entry into a SET state or change of the edited field.
  - `blink_o` starts at 1 and toggles every `BLINK_MS` ticks.
  - It is forced to 0 in IDLE and LOAD.
- **Reset** (asynchronous, at any point, including mid-edit):
  - FSM returns to IDLE.
  - Outputs: `mode_o` = 00, `set_hrs_o` = 12, `set_min_o` = 0, `set_sec_o` = 0, `set_time_o` = 0, `edit_o` = 0, `blink_o` = 0.
  - Working registers, debounce counters and synchronizers are cleared.

## Timing
- **Press to action:** 2 `clk_i` cycles of synchronization, plus `DEBOUNCE_MS` ticks, plus 1 cycle for edge detection. The state or field update is registered on the following `clk_i` edge.
- **Load strobe:** `set_time_o` is high for exactly one `clk_i` cycle, the cycle after the next event accepted in SET_SEC. `set_*_o` take their new values in that same cycle and hold until the next LOAD or reset.
- **Mode change:** `mode_o` updates one cycle after the mode event.
- **Release:** no action on button release; a held button produces one event (unless auto-repeat is enabled).

## Configuration
- **`CLOCK_SET_AUTOREPEAT_EN` defined:** in SET states, an up or down button held at debounced level 1 for `REPEAT_DELAY_MS` ticks generates an extra step. Further steps follow every `REPEAT_RATE_MS` ticks until release. The repeat counter clears on release, on a field change and on reset.
- **Not defined:** the repeat logic is absent, so there is exactly one step per press. The `REPEAT_*` parameters are unused.

## Test plan
Benches drive `tick_i` = 1 every cycle and set `DEBOUNCE_MS` = 4.

1. Reset applied mid-SET_MIN → outputs immediately read 00/12/0/0/0, `edit_o` = 0, `blink_o` = 0.
2. Four mode presses in IDLE → `mode_o` steps 01, 10, 11, 00. A 2-cycle glitch on `btn_mode_i` → no change.
3. Sequence next, up ×3, next, down ×1, next, up ×2, next → a single `set_time_o` pulse with hrs = 15, min = 59, sec = 2. `edit_o` steps 1, 2, 3, 0.
4. Edit hrs from 12 to 13, then press mode → return to IDLE, no strobe, `set_hrs_o` stays 12, `mode_o` unchanged.
5. up and down debounced in the same cycle in SET_SEC → field unchanged. next and up in the same cycle → advance to LOAD with sec unchanged.
6. With `CLOCK_SET_AUTOREPEAT_EN`, `REPEAT_DELAY_MS` = 10, `REPEAT_RATE_MS` = 5: hold up in SET_MIN for 30 ticks from min = 58 → 1 + 1 + 4 steps, so min = 4. Without the macro → min = 59.
